rf_write_arbiter: RTL and testbench

- Shares the single register-file write port between two writers: the pipeline writeback stage (WB) and the multi-cycle execution unit (MC).
- MC results are buffered in a 2-entry FIFO. WB has priority, but a starvation limit forces an MC grant and stalls WB.
- Also reports read-after-write hazards against buffered MC results, so decode can stall.
- Sits between WB/MC and the register file write port; its query ports are driven by decode.

---
 rtl/CPU_def.sv | 16 +
 rtl/rf_write_arbiter_fifo.sv | 77 +++++++
 rtl/rf_write_arbiter.sv | 127 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/CPU_def.sv
// Shared CPU definitions: datapath widths and the register-file write record
// used by the write-port arbiter and its MC result buffer.
package CPU_def;

    localparam int PC_BITS      = 32;
    localparam int PC_ADDR_SIZE = 5;

    // Register 0 is hard-wired; writes to it are dropped at the port.
    localparam logic [PC_ADDR_SIZE-1:0] RF_ZERO_ADDR = '0;

    typedef struct packed {
        logic [PC_ADDR_SIZE-1:0] addr;
        logic [PC_BITS-1:0]      data;
    } rf_wr_t;

endpackage

// File: rtl/rf_write_arbiter_fifo.sv
// Small in-order buffer for multi-cycle unit register writes. It exposes every
// slot's valid bit and address so the hazard compare can see the whole buffer.
module rf_wr_fifo #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [ADDR_W-1:0]         push_addr,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic [ADDR_W-1:0]         head_addr,
    output logic [DATA_W-1:0]         head_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic [DEPTH-1:0]          entry_valid,
    output logic [DEPTH*ADDR_W-1:0]   entry_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic do_push;
    logic do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Payload storage needs no reset: slot validity is derived from the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr_reg] <= push_addr;
            data_mem[wr_ptr_reg] <= push_data;
        end
    end

    assign head_addr = addr_mem[rd_ptr_reg];
    assign head_data = data_mem[rd_ptr_reg];
    assign count     = count_reg;

    // A slot is live when its distance from the read pointer is below the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [PTR_W-1:0] offset;
        assign offset                           = PTR_W'(gi) - rd_ptr_reg;
        assign entry_valid[gi]                  = ({1'b0, offset} < count_reg);
        assign entry_addr[gi*ADDR_W +: ADDR_W]  = addr_mem[gi];
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between writeback and the buffered
// multi-cycle unit results, with a starvation guard and decode hazard lookup.
module rf_write_arbiter
    import CPU_def::*;
#(
    parameter int DATA_W       = PC_BITS,
    parameter int ADDR_W       = PC_ADDR_SIZE,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          halt,
    input  logic                          wb_valid,
    input  logic [ADDR_W-1:0]             wb_addr,
    input  logic [DATA_W-1:0]             wb_data,
    output logic                          stall_wb,
    input  logic                          mc_valid,
    input  logic [ADDR_W-1:0]             mc_addr,
    input  logic [DATA_W-1:0]             mc_data,
    output logic                          mc_ready,
    output logic                          rf_we,
    output logic [ADDR_W-1:0]             rf_waddr,
    output logic [DATA_W-1:0]             rf_wdata,
    input  logic [ADDR_W-1:0]             q_addr_1,
    input  logic [ADDR_W-1:0]             q_addr_2,
    output logic                          q_pending_1,
    output logic                          q_pending_2,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_ADDR);

    logic                         fifo_push;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [ADDR_W-1:0]            head_addr;
    logic [DATA_W-1:0]            head_data;
    logic [FIFO_DEPTH-1:0]        entry_valid;
    logic [FIFO_DEPTH*ADDR_W-1:0] entry_addr;

    logic                         grant_wb;
    logic                         grant_fifo;
    logic                         starve_at_limit;
    logic [STARVE_W-1:0]          starve_cnt_reg;
    logic [STARVE_W-1:0]          starve_cnt_next;

    logic [FIFO_DEPTH-1:0]        match_1;
    logic [FIFO_DEPTH-1:0]        match_2;

    // mc_ready looks only at the registered occupancy, never at a same-cycle pop.
    assign mc_ready  = !fifo_full;
    assign fifo_push = mc_valid && mc_ready && !halt;

    rf_wr_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo_push),
        .push_addr   (mc_addr),
        .push_data   (mc_data),
        .pop         (grant_fifo),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    assign starve_at_limit = (starve_cnt_reg == STARVE_W'(STARVE_LIMIT));

    always_comb begin
        grant_wb   = 1'b0;
        grant_fifo = 1'b0;
        stall_wb   = 1'b0;
        if (halt) begin
            stall_wb = wb_valid;
        end else if (!fifo_empty && wb_valid && starve_at_limit) begin
            grant_fifo = 1'b1;
            stall_wb   = 1'b1;
        end else if (wb_valid) begin
            grant_wb = 1'b1;
        end else if (!fifo_empty) begin
            grant_fifo = 1'b1;
        end
    end

    assign rf_waddr = grant_fifo ? head_addr : wb_addr;
    assign rf_wdata = grant_fifo ? head_data : wb_data;
    // A register-0 grant still consumes the slot; only the enable is dropped.
    assign rf_we    = (grant_wb || grant_fifo) && (rf_waddr != ZERO_ADDR);

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!halt) begin
            if (fifo_empty || grant_fifo) begin
                starve_cnt_next = '0;
            end else if (grant_wb && !starve_at_limit) begin
                starve_cnt_next = starve_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // The head being popped this cycle still counts as pending for decode.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_query
        assign match_1[gi] = entry_valid[gi] && (entry_addr[gi*ADDR_W +: ADDR_W] == q_addr_1);
        assign match_2[gi] = entry_valid[gi] && (entry_addr[gi*ADDR_W +: ADDR_W] == q_addr_2);
    end

    assign q_pending_1 = (q_addr_1 != ZERO_ADDR) && (|match_1);
    assign q_pending_2 = (q_addr_2 != ZERO_ADDR) && (|match_2);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus a random
// run checked against a queue-based model of the arbitration rules.
module tb_rf_write_arbiter;
    import CPU_def::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;
    localparam int LIMIT  = 3;

    logic              clk;
    logic              rst;
    logic              halt;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              stall_wb;
    logic              mc_valid;
    logic [ADDR_W-1:0] mc_addr;
    logic [DATA_W-1:0] mc_data;
    logic              mc_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] q_addr_1;
    logic [ADDR_W-1:0] q_addr_2;
    logic              q_pending_1;
    logic              q_pending_2;
    logic [1:0]        fifo_count;

    int errors = 0;
    int checks = 0;

    rf_write_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .stall_wb(stall_wb),
        .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data), .mc_ready(mc_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .q_addr_1(q_addr_1), .q_addr_2(q_addr_2),
        .q_pending_1(q_pending_1), .q_pending_2(q_pending_2),
        .fifo_count(fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // Behavioural model: an ordered queue of pending writes plus a loss counter.
    rf_wr_t            m_q[$];
    int                m_starve;
    logic              e_grant_wb, e_grant_fifo, e_stall, e_ready, e_we, e_p1, e_p2;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    int                e_count;

    task automatic model_eval();
        int n = m_q.size();
        e_grant_wb   = 1'b0;
        e_grant_fifo = 1'b0;
        e_stall      = 1'b0;
        e_ready      = (n < DEPTH);
        if (halt) e_stall = wb_valid;
        else if (n > 0 && wb_valid && m_starve == LIMIT) begin
            e_grant_fifo = 1'b1;
            e_stall      = 1'b1;
        end else if (wb_valid) e_grant_wb = 1'b1;
        else if (n > 0) e_grant_fifo = 1'b1;
        e_addr = e_grant_fifo ? m_q[0].addr : wb_addr;
        e_data = e_grant_fifo ? m_q[0].data : wb_data;
        e_we   = (e_grant_wb || e_grant_fifo) && (e_addr != 0);
        e_p1   = 1'b0;
        e_p2   = 1'b0;
        foreach (m_q[i]) begin
            if (q_addr_1 != 0 && m_q[i].addr == q_addr_1) e_p1 = 1'b1;
            if (q_addr_2 != 0 && m_q[i].addr == q_addr_2) e_p2 = 1'b1;
        end
        e_count = n;
    endtask

    task automatic model_commit();
        int n = m_q.size();
        rf_wr_t ent;
        if (!halt) begin
            if (n == 0 || e_grant_fifo) m_starve = 0;
            else if (e_grant_wb && m_starve < LIMIT) m_starve = m_starve + 1;
            if (e_grant_fifo) void'(m_q.pop_front());
            if (mc_valid && e_ready) begin
                ent.addr = mc_addr;
                ent.data = mc_data;
                m_q.push_back(ent);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        halt = 0; wb_valid = 0; wb_addr = '0; wb_data = '0;
        mc_valid = 0; mc_addr = '0; mc_data = '0; q_addr_1 = '0; q_addr_2 = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        q_addr_1 = 5'd3;
        q_addr_2 = 5'd5;
        #1;
        checks++;
        if ({mc_ready, rf_we, stall_wb, fifo_count} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%0b we=%0b stall=%0b cnt=%0d want 1 0 0 0",
                     mc_ready, rf_we, stall_wb, fifo_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({q_pending_1, q_pending_2, mc_ready, rf_we, fifo_count} !== {1'b0, 1'b0, 1'b1, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_idle: got p1=%0b p2=%0b ready=%0b we=%0b cnt=%0d want 0 0 1 0 0",
                     q_pending_1, q_pending_2, mc_ready, rf_we, fifo_count);
        end
        $display("txn reset: ready=%0b we=%0b cnt=%0d", mc_ready, rf_we, fifo_count);
        tick();
    endtask

    task automatic test_mc_alone();
        idle_inputs();
        mc_valid = 1; mc_addr = 5'd7; mc_data = 32'hDEADBEEF;
        #1;
        tick();
        mc_valid = 0;
        #1;
        checks++;
        if ({rf_we, stall_wb, rf_waddr, rf_wdata} !== {1'b1, 1'b0, 5'd7, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL mc_alone_write: got we=%0b stall=%0b addr=%0d data=%h want 1 0 7 deadbeef",
                     rf_we, stall_wb, rf_waddr, rf_wdata);
        end
        $display("txn mc_alone: we=%0b addr=%0d data=%h", rf_we, rf_waddr, rf_wdata);
        tick();
        #1;
        checks++;
        if ({fifo_count, rf_we} !== {2'd0, 1'b0}) begin
            errors++;
            $display("FAIL mc_alone_drain: got cnt=%0d we=%0b want 0 0", fifo_count, rf_we);
        end
        tick();
    endtask

    task automatic test_starvation();
        idle_inputs();
        wb_valid = 1; wb_addr = 5'd9; wb_data = 32'h0000_0909;
        mc_valid = 1; mc_addr = 5'd4; mc_data = 32'h0000_4444;
        #1;
        tick();
        mc_valid = 0;
        for (int k = 0; k < LIMIT; k++) begin
            #1;
            checks++;
            if ({rf_we, stall_wb, rf_waddr} !== {1'b1, 1'b0, 5'd9}) begin
                errors++;
                $display("FAIL starve_wb_win%0d: got we=%0b stall=%0b addr=%0d want 1 0 9",
                         k, rf_we, stall_wb, rf_waddr);
            end
            tick();
        end
        #1;
        checks++;
        if ({rf_we, stall_wb, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'd4, 32'h0000_4444}) begin
            errors++;
            $display("FAIL starve_forced: got we=%0b stall=%0b addr=%0d data=%h want 1 1 4 00004444",
                     rf_we, stall_wb, rf_waddr, rf_wdata);
        end
        $display("txn starve_forced: addr=%0d stall=%0b", rf_waddr, stall_wb);
        tick();
        #1;
        checks++;
        if ({rf_we, stall_wb, rf_waddr, fifo_count} !== {1'b1, 1'b0, 5'd9, 2'd0}) begin
            errors++;
            $display("FAIL starve_after: got we=%0b stall=%0b addr=%0d cnt=%0d want 1 0 9 0",
                     rf_we, stall_wb, rf_waddr, fifo_count);
        end
        wb_valid = 0;
        tick();
    endtask

    task automatic test_full();
        idle_inputs();
        wb_valid = 1; wb_addr = 5'd9; wb_data = 32'h99;
        mc_valid = 1; mc_addr = 5'd1; mc_data = 32'h11;
        #1;
        tick();
        mc_addr = 5'd2; mc_data = 32'h22;
        #1;
        checks++;
        if (mc_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_ready_one: got %0b want 1", mc_ready);
        end
        tick();
        mc_addr = 5'd3; mc_data = 32'h33;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({mc_ready, fifo_count, rf_waddr} !== {1'b0, 2'd2, 5'd9}) begin
                errors++;
                $display("FAIL full_backpressure%0d: got ready=%0b cnt=%0d addr=%0d want 0 2 9",
                         k, mc_ready, fifo_count, rf_waddr);
            end
            tick();
        end
        #1;
        checks++;
        if ({mc_ready, stall_wb, rf_we, rf_waddr} !== {1'b0, 1'b1, 1'b1, 5'd1}) begin
            errors++;
            $display("FAIL full_pop: got ready=%0b stall=%0b we=%0b addr=%0d want 0 1 1 1",
                     mc_ready, stall_wb, rf_we, rf_waddr);
        end
        tick();
        mc_valid = 0;
        wb_valid = 0;
        #1;
        checks++;
        if ({mc_ready, fifo_count, rf_we, rf_waddr, rf_wdata} !== {1'b1, 2'd1, 1'b1, 5'd2, 32'h22}) begin
            errors++;
            $display("FAIL full_recover: got ready=%0b cnt=%0d we=%0b addr=%0d data=%h want 1 1 1 2 22",
                     mc_ready, fifo_count, rf_we, rf_waddr, rf_wdata);
        end
        $display("txn full_recover: ready=%0b cnt=%0d addr=%0d", mc_ready, fifo_count, rf_waddr);
        tick();
        #1;
        checks++;
        if ({fifo_count, rf_we} !== {2'd0, 1'b0}) begin
            errors++;
            $display("FAIL full_third_dropped: got cnt=%0d we=%0b want 0 0", fifo_count, rf_we);
        end
        tick();
    endtask

    task automatic test_hazard_zero();
        idle_inputs();
        wb_valid = 1; wb_addr = 5'd9; wb_data = 32'h99;
        mc_valid = 1; mc_addr = 5'd12; mc_data = 32'hC0C0;
        #1;
        tick();
        mc_addr = 5'd0; mc_data = 32'h0BAD;
        #1;
        tick();
        mc_valid = 0;
        q_addr_1 = 5'd12;
        q_addr_2 = 5'd0;
        #1;
        checks++;
        if ({fifo_count, q_pending_1, q_pending_2} !== {2'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL hazard_query: got cnt=%0d p1=%0b p2=%0b want 2 1 0",
                     fifo_count, q_pending_1, q_pending_2);
        end
        tick();
        wb_valid = 0;
        #1;
        checks++;
        if ({rf_we, rf_waddr, q_pending_1} !== {1'b1, 5'd12, 1'b1}) begin
            errors++;
            $display("FAIL hazard_pop12: got we=%0b addr=%0d p1=%0b want 1 12 1",
                     rf_we, rf_waddr, q_pending_1);
        end
        tick();
        #1;
        checks++;
        if ({rf_we, stall_wb, fifo_count, q_pending_1} !== {1'b0, 1'b0, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL zero_pop: got we=%0b stall=%0b cnt=%0d p1=%0b want 0 0 1 0",
                     rf_we, stall_wb, fifo_count, q_pending_1);
        end
        $display("txn zero_pop: we=%0b cnt=%0d", rf_we, fifo_count);
        tick();
        #1;
        checks++;
        if (fifo_count !== 2'd0) begin
            errors++;
            $display("FAIL zero_drained: got cnt=%0d want 0", fifo_count);
        end
        tick();
    endtask

    task automatic test_halt();
        idle_inputs();
        wb_valid = 1; wb_addr = 5'd9; wb_data = 32'h99;
        mc_valid = 1; mc_addr = 5'd5; mc_data = 32'h55;
        #1;
        tick();
        mc_valid = 0;
        #1;
        tick();
        halt = 1;
        mc_valid = 1; mc_addr = 5'd6; mc_data = 32'h66;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({rf_we, stall_wb, fifo_count} !== {1'b0, 1'b1, 2'd1}) begin
                errors++;
                $display("FAIL halt_cycle%0d: got we=%0b stall=%0b cnt=%0d want 0 1 1",
                         k, rf_we, stall_wb, fifo_count);
            end
            tick();
        end
        halt = 0;
        mc_valid = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({rf_we, stall_wb, rf_waddr} !== {1'b1, 1'b0, 5'd9}) begin
                errors++;
                $display("FAIL halt_resume_wb%0d: got we=%0b stall=%0b addr=%0d want 1 0 9",
                         k, rf_we, stall_wb, rf_waddr);
            end
            tick();
        end
        #1;
        checks++;
        if ({rf_we, stall_wb, rf_waddr} !== {1'b1, 1'b1, 5'd5}) begin
            errors++;
            $display("FAIL halt_starve_held: got we=%0b stall=%0b addr=%0d want 1 1 5",
                     rf_we, stall_wb, rf_waddr);
        end
        $display("txn halt_resume: addr=%0d stall=%0b", rf_waddr, stall_wb);
        tick();
        wb_valid = 0;
        #1;
        checks++;
        if (fifo_count !== 2'd0) begin
            errors++;
            $display("FAIL halt_push_ignored: got cnt=%0d want 0", fifo_count);
        end
        tick();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        wb_valid = 1; wb_addr = 5'd9; wb_data = 32'h99;
        mc_valid = 1; mc_addr = 5'd10; mc_data = 32'hA;
        #1;
        tick();
        mc_addr = 5'd11; mc_data = 32'hB;
        #1;
        tick();
        mc_valid = 0;
        wb_valid = 0;
        q_addr_1 = 5'd10;
        q_addr_2 = 5'd11;
        #1;
        checks++;
        if ({fifo_count, q_pending_1, q_pending_2} !== {2'd2, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL areset_pre: got cnt=%0d p1=%0b p2=%0b want 2 1 1",
                     fifo_count, q_pending_1, q_pending_2);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({fifo_count, q_pending_1, q_pending_2, mc_ready, rf_we} !== {2'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL areset_immediate: got cnt=%0d p1=%0b p2=%0b ready=%0b we=%0b want 0 0 0 1 0",
                     fifo_count, q_pending_1, q_pending_2, mc_ready, rf_we);
        end
        $display("txn async_reset: cnt=%0d p1=%0b", fifo_count, q_pending_1);
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_q.delete();
        m_starve = 0;
        for (int c = 0; c < 200; c++) begin
            halt     = ($urandom_range(9) == 0);
            wb_valid = $urandom_range(1);
            wb_addr  = ADDR_W'($urandom_range(7));
            wb_data  = $urandom;
            mc_valid = ($urandom_range(9) < 6);
            mc_addr  = ADDR_W'($urandom_range(7));
            mc_data  = $urandom;
            q_addr_1 = ADDR_W'($urandom_range(7));
            q_addr_2 = ADDR_W'($urandom_range(7));
            #1;
            model_eval();
            checks++;
            if ({rf_we, stall_wb, mc_ready} !== {e_we, e_stall, e_ready}) begin
                errors++;
                $display("FAIL rand_ctrl c=%0d: got we=%0b stall=%0b ready=%0b want %0b %0b %0b",
                         c, rf_we, stall_wb, mc_ready, e_we, e_stall, e_ready);
            end
            checks++;
            if ({q_pending_1, q_pending_2} !== {e_p1, e_p2} || int'(fifo_count) != e_count) begin
                errors++;
                $display("FAIL rand_state c=%0d: got p1=%0b p2=%0b cnt=%0d want %0b %0b %0d",
                         c, q_pending_1, q_pending_2, fifo_count, e_p1, e_p2, e_count);
            end
            if (e_we) begin
                checks++;
                if ({rf_waddr, rf_wdata} !== {e_addr, e_data}) begin
                    errors++;
                    $display("FAIL rand_write c=%0d: got addr=%0d data=%h want %0d %h",
                             c, rf_waddr, rf_wdata, e_addr, e_data);
                end
            end
            $display("txn rand %0d: halt=%0b wb=%0b mc=%0b we=%0b addr=%0d cnt=%0d",
                     c, halt, wb_valid, mc_valid, rf_we, rf_waddr, fifo_count);
            @(posedge clk);
            model_commit();
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_mc_alone();
        test_starvation();
        test_full();
        test_hazard_zero();
        test_halt();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
